// File: rtl/eva_ahb_sram_slv.sv
// eva_ahb_sram_slv: AHB-Lite responder backed by a word-addressed SRAM array.
// Each accepted transfer gets a data phase of WAIT_CYC wait states, or a
// two-cycle ERROR response if it is out of range, oversized or misaligned.
// Writes commit at the completion edge with byte enables. Read data is driven
// combinationally from the array only during a good read's completion cycle.
module eva_ahb_sram_slv #(
    parameter int          AW        = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          WAIT_CYC  = 0
) (
    input  logic        hclk,
    input  logic        hrest_n,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic        hready_out,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    localparam int          DEPTH    = 1 << AW;
    // Byte span of the array. It is 33 bits wide, so a large AW still gives
    // an exact compare.
    localparam logic [32:0] SPAN     = 33'(1) << (AW + 2);
    localparam logic [3:0]  WAIT_LD  = 4'(WAIT_CYC);
    localparam bit          HAS_WAIT = (WAIT_CYC > 0);

    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_ERROR = 2'b01;

    // Control state
    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            dp_q, dp_d;

    // Captured address-phase information
    logic            write_q, write_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [1:0]      size_q, size_d;

    // Storage (deliberately not reset)
    logic [31:0]     mem [DEPTH];

    // Address-phase decode
    logic            acc;
    logic            bad;
    logic            out_of_range;
    logic            size_bad;
    logic            misaligned;
    logic [31:0]     offset;

    // Data-phase helpers
    logic            complete;
    logic [3:0]      be;

    // Only bit 1 of htrans distinguishes an active transfer (NONSEQ/SEQ).
    logic            unused_htrans0;
    assign unused_htrans0 = htrans[0];

    // Offset from the window base. The window is aligned to SPAN, so the low
    // offset bits are also the low address bits.
    assign offset       = haddr - BASE_ADDR;
    assign out_of_range = ({1'b0, offset} >= SPAN);
    assign size_bad     = (hsize > 3'b010);

    // Misalignment depends on the transfer size
    always_comb begin
        misaligned = 1'b0;
        case (hsize)
            3'b001:  misaligned = haddr[0];
            3'b010:  misaligned = |haddr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign bad = out_of_range | size_bad | misaligned;

    // The slave stalls only in the first ERROR cycle and in wait cycles that
    // still have a non-zero count.
    assign hready_out = !((state_q == ST_ERR1) ||
                          ((state_q == ST_WAIT) && (cnt_q != 4'd0)));

    // A new address is taken only at a data-phase boundary. A slave never
    // samples a new address while it is holding its own data phase.
    assign acc = hsel & htrans[1] & hready_in & hready_out;

    // A good data phase completes in any cycle where the slave is ready
    assign complete = dp_q & hready_out;

    assign hresp = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;

    assign hrdata = (complete & ~write_q) ? mem[addr_q[AW+1:2]] : 32'h0;

    // Next state, wait counter and data-phase-pending flag
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dp_d    = dp_q;
        case (state_q)
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Completion cycle: return to IDLE or chain into the next transfer
                    dp_d = acc & ~bad;
                    if (acc && bad) begin
                        state_d = ST_ERR1;
                    end else if (acc && HAS_WAIT) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                // IDLE and ERR2 are both boundaries where an address may be accepted
                dp_d = acc & ~bad;
                if (acc && bad) begin
                    state_d = ST_ERR1;
                end else if (acc && HAS_WAIT) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Capture address-phase attributes on accept; hold them otherwise
    always_comb begin
        write_d = write_q;
        addr_d  = addr_q;
        size_d  = size_q;
        if (acc) begin
            write_d = hwrite;
            addr_d  = offset[AW+1:0];
            size_d  = hsize[1:0];
        end
    end

    // Control and captured-address registers
    always_ff @(posedge hclk or negedge hrest_n) begin
        if (!hrest_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            dp_q    <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dp_q    <= dp_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
        end
    end

    // Byte lanes touched by the pending write
    always_comb begin
        be = 4'b0000;
        case (size_q)
            2'b00:   be = 4'b0001 << addr_q[1:0];
            2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Commit write data at the completion edge. Reset clears dp_q, which drops the write.
    always_ff @(posedge hclk) begin
        if (complete && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr_q[AW+1:2]][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_eva_ahb_sram_slv.sv
// Directed bench for eva_ahb_sram_slv. It uses three instances: zero wait,
// two wait states and three wait states. A shared bus is steered to one
// instance through tgt.
module tb_eva_ahb_sram_slv;

    logic        hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic        rst_n;
    logic        rst3_n;
    logic        rstn3_w;
    logic        sel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    int          tgt;

    logic        hsel0, hsel2, hsel3;
    logic        rdy0, rdy2, rdy3;
    logic [1:0]  resp0, resp2, resp3;
    logic [31:0] rd0, rd2, rd3;
    logic        rdy_m;
    logic [1:0]  resp_m;
    logic [31:0] rd_m;

    int checks   = 0;
    int failures = 0;

    assign hsel0   = sel && (tgt == 0);
    assign hsel2   = sel && (tgt == 2);
    assign hsel3   = sel && (tgt == 3);
    assign rstn3_w = rst_n & rst3_n;
    assign rdy_m   = (tgt == 0) ? rdy0  : (tgt == 2) ? rdy2  : rdy3;
    assign resp_m  = (tgt == 0) ? resp0 : (tgt == 2) ? resp2 : resp3;
    assign rd_m    = (tgt == 0) ? rd0   : (tgt == 2) ? rd2   : rd3;

    eva_ahb_sram_slv #(.AW(10), .BASE_ADDR(32'h0), .WAIT_CYC(0)) u0 (
        .hclk(hclk), .hrest_n(rst_n), .hsel(hsel0), .htrans(htrans),
        .hwrite(hwrite), .haddr(haddr), .hsize(hsize), .hwdata(hwdata),
        .hready_in(rdy0), .hready_out(rdy0), .hresp(resp0), .hrdata(rd0)
    );

    eva_ahb_sram_slv #(.AW(10), .BASE_ADDR(32'h0), .WAIT_CYC(2)) u2 (
        .hclk(hclk), .hrest_n(rst_n), .hsel(hsel2), .htrans(htrans),
        .hwrite(hwrite), .haddr(haddr), .hsize(hsize), .hwdata(hwdata),
        .hready_in(rdy2), .hready_out(rdy2), .hresp(resp2), .hrdata(rd2)
    );

    eva_ahb_sram_slv #(.AW(10), .BASE_ADDR(32'h0), .WAIT_CYC(3)) u3 (
        .hclk(hclk), .hrest_n(rstn3_w), .hsel(hsel3), .htrans(htrans),
        .hwrite(hwrite), .haddr(haddr), .hsize(hsize), .hwdata(hwdata),
        .hready_in(rdy3), .hready_out(rdy3), .hresp(resp3), .hrdata(rd3)
    );

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_bus();
        sel    = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = 32'h0;
        hsize  = 3'b000;
        hwdata = 32'h0;
    endtask

    // One isolated transfer: address phase, then data phase until ready.
    // waits = -1 means the data phase never completed.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output int waits,
                        output logic [1:0] resp_lo, output logic [1:0] resp_done,
                        output logic [31:0] rd_lo);
        bit done;
        sel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
        step();
        sel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wd;
        waits = 0; resp_lo = 2'b00; resp_done = 2'b11; rd = 32'h0; rd_lo = 32'h0; done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge hclk);
            if (rdy_m) begin
                rd = rd_m; resp_done = resp_m; done = 1'b1;
            end else begin
                waits++; resp_lo = resp_m; rd_lo = rd_lo | rd_m;
            end
            step();
            if (done) break;
        end
        if (!done) waits = -1;
        hwdata = 32'h0;
    endtask

    task automatic test_reset();
        @(negedge hclk);
        checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL reset_ready0: got %b expected 1", rdy0); end
        checks++; if (resp0 !== 2'b00) begin failures++; $display("FAIL reset_resp0: got %b expected 00", resp0); end
        checks++; if (rd0 !== 32'h0) begin failures++; $display("FAIL reset_rdata0: got %h expected 00000000", rd0); end
        checks++; if (rdy2 !== 1'b1 || resp2 !== 2'b00 || rd2 !== 32'h0) begin
            failures++; $display("FAIL reset_u2: got ready=%b resp=%b rdata=%h expected 1/00/0", rdy2, resp2, rd2); end
        checks++; if (rdy3 !== 1'b1 || resp3 !== 2'b00 || rd3 !== 32'h0) begin
            failures++; $display("FAIL reset_u3: got ready=%b resp=%b rdata=%h expected 1/00/0", rdy3, resp3, rd3); end
        @(posedge hclk); #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        tgt = 0;
        sel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'b010;
        step();
        hwdata = 32'hDEAD_BEEF; hwrite = 1'b0;    // read of the same address, back-to-back
        @(negedge hclk);
        checks++; if (rdy_m !== 1'b1) begin failures++; $display("FAIL wr_dphase_ready: got %b expected 1", rdy_m); end
        checks++; if (resp_m !== 2'b00) begin failures++; $display("FAIL wr_dphase_resp: got %b expected 00", resp_m); end
        checks++; if (rd_m !== 32'h0) begin failures++; $display("FAIL wr_dphase_rdata: got %h expected 00000000", rd_m); end
        step();
        sel = 1'b0; htrans = 2'b00; hwdata = 32'h0;
        @(negedge hclk);
        checks++; if (rdy_m !== 1'b1) begin failures++; $display("FAIL rd_dphase_ready: got %b expected 1", rdy_m); end
        checks++; if (resp_m !== 2'b00) begin failures++; $display("FAIL rd_dphase_resp: got %b expected 00", resp_m); end
        checks++; if (rd_m !== 32'hDEAD_BEEF) begin failures++; $display("FAIL raw_rdata: got %h expected deadbeef", rd_m); end
        step();
        @(negedge hclk);
        checks++; if (rd_m !== 32'h0) begin failures++; $display("FAIL rdata_after_read: got %h expected 00000000", rd_m); end
        step();
    endtask

    task automatic test_lanes();
        logic [31:0] rd, rdl;
        logic [1:0]  rl, rdn;
        int          w;
        tgt = 0;
        xfer(1'b1, 32'h20, 3'b010, 32'h1122_3344, rd, w, rl, rdn, rdl);
        xfer(1'b1, 32'h21, 3'b000, 32'h0000_AA00, rd, w, rl, rdn, rdl);
        checks++; if (w !== 0 || rdn !== 2'b00) begin failures++; $display("FAIL byte_write_resp: got waits=%0d resp=%b expected 0/00", w, rdn); end
        xfer(1'b1, 32'h22, 3'b001, 32'hBBCC_0000, rd, w, rl, rdn, rdl);
        xfer(1'b0, 32'h20, 3'b010, 32'h0, rd, w, rl, rdn, rdl);
        checks++; if (rd !== 32'hBBCC_AA44) begin failures++; $display("FAIL lanes_rdata: got %h expected bbccaa44", rd); end
        checks++; if (w !== 0) begin failures++; $display("FAIL lanes_waits: got %0d expected 0", w); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, rdl;
        logic [1:0]  rl, rdn;
        int          w;
        tgt = 0;
        xfer(1'b1, 32'h0, 3'b010, 32'h5A5A_0001, rd, w, rl, rdn, rdl);
        xfer(1'b1, 32'h4, 3'b010, 32'h600D_0004, rd, w, rl, rdn, rdl);
        xfer(1'b1, 32'hFFC, 3'b010, 32'h0BAD_F00D, rd, w, rl, rdn, rdl);
        xfer(1'b0, 32'hFFC, 3'b010, 32'h0, rd, w, rl, rdn, rdl);
        checks++; if (rd !== 32'h0BAD_F00D || w !== 0 || rdn !== 2'b00) begin
            failures++; $display("FAIL last_word: got rdata=%h waits=%0d resp=%b expected 0badf00d/0/00", rd, w, rdn); end
        xfer(1'b0, 32'h1000, 3'b010, 32'h0, rd, w, rl, rdn, rdl);
        checks++; if (w !== 1 || rl !== 2'b01 || rdn !== 2'b01) begin
            failures++; $display("FAIL err_range: got waits=%0d resp1=%b resp2=%b expected 1/01/01", w, rl, rdn); end
        checks++; if (rd !== 32'h0 || rdl !== 32'h0) begin
            failures++; $display("FAIL err_range_rdata: got %h/%h expected 0/0", rdl, rd); end
        xfer(1'b1, 32'h2, 3'b010, 32'hFFFF_FFFF, rd, w, rl, rdn, rdl);
        checks++; if (w !== 1 || rl !== 2'b01 || rdn !== 2'b01) begin
            failures++; $display("FAIL err_misalign_word: got waits=%0d resp1=%b resp2=%b expected 1/01/01", w, rl, rdn); end
        xfer(1'b1, 32'h4, 3'b011, 32'hFFFF_FFFF, rd, w, rl, rdn, rdl);
        checks++; if (w !== 1 || rdn !== 2'b01) begin
            failures++; $display("FAIL err_size: got waits=%0d resp=%b expected 1/01", w, rdn); end
        xfer(1'b1, 32'h5, 3'b001, 32'hFFFF_FFFF, rd, w, rl, rdn, rdl);
        checks++; if (w !== 1 || rdn !== 2'b01) begin
            failures++; $display("FAIL err_misalign_half: got waits=%0d resp=%b expected 1/01", w, rdn); end
        xfer(1'b0, 32'h0, 3'b010, 32'h0, rd, w, rl, rdn, rdl);
        checks++; if (rd !== 32'h5A5A_0001 || rdn !== 2'b00) begin
            failures++; $display("FAIL err_no_write0: got %h resp=%b expected 5a5a0001/00", rd, rdn); end
        xfer(1'b0, 32'h4, 3'b010, 32'h0, rd, w, rl, rdn, rdl);
        checks++; if (rd !== 32'h600D_0004) begin failures++; $display("FAIL err_no_write4: got %h expected 600d0004", rd); end
    endtask

    task automatic test_idle_busy();
        logic [31:0] rd, rdl;
        logic [1:0]  rl, rdn;
        int          w;
        tgt = 0;
        xfer(1'b1, 32'h40, 3'b010, 32'h0102_0304, rd, w, rl, rdn, rdl);
        for (int k = 0; k < 3; k++) begin
            sel    = (k < 2);
            htrans = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b10;
            hwrite = 1'b1; haddr = 32'h40; hsize = 3'b010;
            step();
            sel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hFFFF_FFFF;
            @(negedge hclk);
            checks++; if (rdy_m !== 1'b1 || resp_m !== 2'b00) begin
                failures++; $display("FAIL noxfer_%0d: got ready=%b resp=%b expected 1/00", k, rdy_m, resp_m); end
            step();
            hwdata = 32'h0;
        end
        xfer(1'b0, 32'h40, 3'b010, 32'h0, rd, w, rl, rdn, rdl);
        checks++; if (rd !== 32'h0102_0304) begin failures++; $display("FAIL noxfer_nowrite: got %h expected 01020304", rd); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, rdl;
        logic [1:0]  rl, rdn;
        int          w;
        logic [5:0]  rdyv;
        logic [31:0] rdv [6];
        tgt = 2;
        xfer(1'b1, 32'h100, 3'b010, 32'hA1A1_A1A1, rd, w, rl, rdn, rdl);
        checks++; if (w !== 2 || rdn !== 2'b00) begin failures++; $display("FAIL wait_write: got waits=%0d resp=%b expected 2/00", w, rdn); end
        xfer(1'b1, 32'h104, 3'b010, 32'hB2B2_B2B2, rd, w, rl, rdn, rdl);
        xfer(1'b0, 32'h100, 3'b010, 32'h0, rd, w, rl, rdn, rdl);
        checks++; if (w !== 2 || rd !== 32'hA1A1_A1A1 || rdl !== 32'h0 || rl !== 2'b00) begin
            failures++; $display("FAIL wait_read: got waits=%0d rdata=%h wait_rdata=%h resp=%b expected 2/a1a1a1a1/0/00", w, rd, rdl, rl); end
        // Back-to-back: the second address is held until the first completes
        sel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h100; hsize = 3'b010;
        step();
        haddr = 32'h104;
        for (int i = 0; i < 6; i++) begin
            @(negedge hclk);
            rdyv[i] = rdy_m;
            rdv[i]  = rd_m;
            step();
            if (i == 2) begin sel = 1'b0; htrans = 2'b00; end
        end
        checks++; if (rdyv !== 6'b100100) begin failures++; $display("FAIL b2b_ready_pattern: got %b expected 100100", rdyv); end
        checks++; if (rdv[2] !== 32'hA1A1_A1A1) begin failures++; $display("FAIL b2b_rdata1: got %h expected a1a1a1a1", rdv[2]); end
        checks++; if (rdv[5] !== 32'hB2B2_B2B2) begin failures++; $display("FAIL b2b_rdata2: got %h expected b2b2b2b2", rdv[5]); end
        checks++; if (rdv[0] !== 32'h0 || rdv[3] !== 32'h0) begin
            failures++; $display("FAIL b2b_rdata_wait: got %h/%h expected 0/0", rdv[0], rdv[3]); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd, rdl;
        logic [1:0]  rl, rdn;
        int          w;
        tgt = 3;
        xfer(1'b1, 32'h80, 3'b010, 32'hCAFE_0000, rd, w, rl, rdn, rdl);
        checks++; if (w !== 3) begin failures++; $display("FAIL wait3_write: got waits=%0d expected 3", w); end
        sel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h80; hsize = 3'b010;
        step();
        sel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h1234_5678;
        @(negedge hclk);
        checks++; if (rdy_m !== 1'b0) begin failures++; $display("FAIL midwait_first: got ready=%b expected 0", rdy_m); end
        step();
        checks++; if (rdy_m !== 1'b0) begin failures++; $display("FAIL midwait_second: got ready=%b expected 0", rdy_m); end
        rst3_n = 1'b0;
        #1;
        checks++; if (rdy_m !== 1'b1 || resp_m !== 2'b00 || rd_m !== 32'h0) begin
            failures++; $display("FAIL midwait_reset_out: got ready=%b resp=%b rdata=%h expected 1/00/0", rdy_m, resp_m, rd_m); end
        step();
        step();
        rst3_n = 1'b1;
        hwdata = 32'h0;
        step();
        xfer(1'b0, 32'h80, 3'b010, 32'h0, rd, w, rl, rdn, rdl);
        checks++; if (rd !== 32'hCAFE_0000 || w !== 3) begin
            failures++; $display("FAIL midwait_dropped: got rdata=%h waits=%0d expected cafe0000/3", rd, w); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tgt    = 0;
        rst_n  = 1'b0;
        rst3_n = 1'b1;
        idle_bus();
        repeat (3) @(posedge hclk);
        test_reset();
        test_write_read();
        test_lanes();
        test_errors();
        test_idle_busy();
        test_wait_states();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
